// File: rtl/cfg_space_arbiter.sv
// cfg_space_arbiter: shares one single-beat config-space port between the
// link-training FSM (requester 0) and the sideband handler (requester 1).
// Round-robin grant, one access in flight, fixed read latency, and
// requester-1 writes into the protected range are refused with err.
module cfg_space_arbiter #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 32,
    parameter int                RD_LAT    = 2,
    parameter logic [ADDR_W-1:0] PROT_BASE = 8'hC0
) (
    input  logic              local_clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_done,
    output logic              req0_err,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_done,
    output logic              req1_err,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              c_read,
    output logic              c_write,
    output logic [ADDR_W-1:0] c_address,
    output logic [DATA_W-1:0] c_data_in,
    input  logic [DATA_W-1:0] c_data_out,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    // WAIT lasts RD_LAT cycles: counter runs RD_LAT-1 down to 0.
    localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

    state_t            state;
    logic              owner;
    logic              wr;
    logic              rej;
    logic              last_grant;
    logic [3:0]        cnt;

    logic              sel1;
    logic              take;
    logic              s_write;
    logic              s_rej;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;

    // Grant: requester 1 wins if alone, or if both pending and 0 went last.
    // Ready is gated by rst so nothing is offered while reset is held.
    always_comb begin
        sel1       = req1_valid && (!req0_valid || !last_grant);
        req0_ready = rst && (state == IDLE) && req0_valid && !sel1;
        req1_ready = rst && (state == IDLE) && sel1;
        take       = req0_ready || req1_ready;
        s_write    = sel1 ? req1_write : req0_write;
        s_addr     = sel1 ? req1_addr  : req0_addr;
        s_wdata    = sel1 ? req1_wdata : req0_wdata;
        s_rej      = sel1 && req1_write && (req1_addr >= PROT_BASE);
    end

    // Main FSM; strobes are loaded at accept so they appear in the ISSUE cycle,
    // done/err are loaded on entry to DONE so they appear in the DONE cycle.
    always_ff @(posedge local_clk) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            wr         <= 1'b0;
            rej        <= 1'b0;
            cnt        <= '0;
            last_grant <= 1'b1;
            c_read     <= 1'b0;
            c_write    <= 1'b0;
            c_address  <= '0;
            c_data_in  <= '0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_err   <= 1'b0;
            req1_err   <= 1'b0;
            req0_rdata <= '0;
            req1_rdata <= '0;
            busy       <= 1'b0;
        end else begin
            c_read    <= 1'b0;
            c_write   <= 1'b0;
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            req0_err  <= 1'b0;
            req1_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        owner      <= sel1;
                        last_grant <= sel1;
                        wr         <= s_write;
                        rej        <= s_rej;
                        c_address  <= s_addr;
                        c_data_in  <= s_wdata;
                        c_read     <= !s_write;
                        c_write    <= s_write && !s_rej;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (wr) begin
                        if (owner) begin
                            req1_done <= 1'b1;
                            req1_err  <= rej;
                        end else begin
                            req0_done <= 1'b1;
                            req0_err  <= rej;
                        end
                        state <= DONE;
                    end else begin
                        cnt   <= CNT_INIT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        if (owner) begin
                            req1_rdata <= c_data_out;
                            req1_done  <= 1'b1;
                        end else begin
                            req0_rdata <= c_data_out;
                            req0_done  <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_space_arbiter.sv
// Directed bench for cfg_space_arbiter. Three instances share requester
// stimulus: index 0 has RD_LAT=2, index 1 RD_LAT=1, index 2 RD_LAT=5.
// Config-space read data is a cycle-stamped pattern so the capture cycle is
// observable in rdata.
module tb_cfg_space_arbiter;

    logic        local_clk = 1'b0;
    logic        rst;
    logic        r0v, r0w, r1v, r1w;
    logic [7:0]  r0a, r1a;
    logic [31:0] r0d, r1d;
    logic [31:0] cyc = 32'd0;
    logic [31:0] cdo;

    logic        rdy0[3], rdy1[3], dn0[3], dn1[3], er0[3], er1[3];
    logic [31:0] rd0[3], rd1[3], cdi[3];
    logic        crd[3], cwr[3], bsy[3];
    logic [7:0]  cad[3];

    int          checks = 0;
    int          errors = 0;
    int          viol = 0;
    logic        prev_rd = 1'b0, prev_wr = 1'b0;
    logic [31:0] exp_rd0;

    always #5 local_clk = ~local_clk;
    always @(posedge local_clk) cyc <= cyc + 32'd1;
    assign cdo = 32'hDEADBEEF ^ cyc;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        cfg_space_arbiter #(
            .ADDR_W(8), .DATA_W(32),
            .RD_LAT(g == 0 ? 2 : (g == 1 ? 1 : 5)),
            .PROT_BASE(8'hC0)
        ) u_dut (
            .local_clk(local_clk), .rst(rst),
            .req0_valid(r0v), .req0_write(r0w), .req0_addr(r0a), .req0_wdata(r0d),
            .req0_ready(rdy0[g]), .req0_done(dn0[g]), .req0_err(er0[g]), .req0_rdata(rd0[g]),
            .req1_valid(r1v), .req1_write(r1w), .req1_addr(r1a), .req1_wdata(r1d),
            .req1_ready(rdy1[g]), .req1_done(dn1[g]), .req1_err(er1[g]), .req1_rdata(rd1[g]),
            .c_read(crd[g]), .c_write(cwr[g]), .c_address(cad[g]), .c_data_in(cdi[g]),
            .c_data_out(cdo), .busy(bsy[g])
        );
    end

    // Strobe / ready sanity on the RD_LAT=2 instance across the whole run.
    always @(negedge local_clk) begin
        if ((crd[0] && cwr[0]) || (crd[0] && prev_rd) || (cwr[0] && prev_wr) ||
            (rdy0[0] && rdy1[0]))
            viol++;
        prev_rd = crd[0];
        prev_wr = cwr[0];
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge local_clk);
        #2;
    endtask

    // Waits (bounded) for a ready on instance 0; returns grantee and cycle.
    task automatic wait_grant(output int who, output int at);
        who = -1;
        at  = 0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (rdy0[0] || rdy1[0]) begin
                who = rdy0[0] ? 0 : 1;
                at  = int'(cyc);
                return;
            end
            tick();
        end
        checks++; errors++;
        $display("FAIL grant_timeout: got no ready, need ready within 30 cycles");
    endtask

    task automatic test_reset();
        rst = 1'b0;
        r0v = 1'b1; r0w = 1'b1; r0a = 8'h01; r0d = 32'h1;
        r1v = 1'b1; r1w = 1'b1; r1a = 8'h02; r1d = 32'h2;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({rdy0[0], rdy1[0], dn0[0], dn1[0], er0[0], er1[0], rd0[0], rd1[0],
                 crd[0], cwr[0], cad[0], cdi[0], bsy[0]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got %h %h %h %h %h %h %h %h, need all 0",
                         rdy0[0], rdy1[0], dn0[0], dn1[0], rd0[0], rd1[0], cad[0], bsy[0]);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({rdy0[0], rdy1[0]} !== 2'b10) begin
            errors++;
            $display("FAIL reset_first_grant: got ready=%b, need 10", {rdy0[0], rdy1[0]});
        end
        r0v = 1'b0; r1v = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        int who, at, prev;
        r0v = 1'b1; r0w = 1'b1; r0a = 8'h20; r0d = 32'h0000_2020;
        r1v = 1'b1; r1w = 1'b1; r1a = 8'h21; r1d = 32'h0000_2121;
        prev = 0;
        for (int n = 0; n < 4; n++) begin
            wait_grant(who, at);
            checks++;
            if (who != n % 2) begin
                errors++;
                $display("FAIL rr_grant%0d: got %0d, need %0d", n, who, n % 2);
            end
            if (n > 0) begin
                checks++;
                if (at - prev != 3) begin
                    errors++;
                    $display("FAIL rr_spacing%0d: got %0d, need 3", n, at - prev);
                end
            end
            prev = at;
            tick();
            if (n == 3) begin r0v = 1'b0; r1v = 1'b0; end
            checks++;
            if ({cwr[0], cad[0], cdi[0]} !==
                {1'b1, (n % 2 == 1) ? 8'h21 : 8'h20, (n % 2 == 1) ? 32'h2121 : 32'h2020}) begin
                errors++;
                $display("FAIL rr_issue%0d: got wr=%b addr=%h data=%h", n, cwr[0], cad[0], cdi[0]);
            end
        end
        tick();
        tick();
        checks++;
        if (bsy[0] !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle_busy: got %b, need 0", bsy[0]);
        end
    endtask

    task automatic test_read();
        int who, at;
        r0v = 1'b1; r0w = 1'b0; r0a = 8'h10;
        wait_grant(who, at);
        checks++;
        if (who != 0) begin
            errors++;
            $display("FAIL read_grant: got %0d, need 0", who);
        end
        tick();
        r0v = 1'b0;
        checks++;
        if ({crd[0], cwr[0], cad[0], bsy[0], dn0[0]} !== {1'b1, 1'b0, 8'h10, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL read_issue: got rd=%b wr=%b addr=%h busy=%b done=%b",
                     crd[0], cwr[0], cad[0], bsy[0], dn0[0]);
        end
        tick();
        checks++;
        if (crd[0] !== 1'b0) begin
            errors++;
            $display("FAIL read_strobe_len: got %b, need 0", crd[0]);
        end
        tick();
        checks++;
        if (dn0[0] !== 1'b0) begin
            errors++;
            $display("FAIL read_early_done: got %b, need 0", dn0[0]);
        end
        tick();
        exp_rd0 = 32'hDEADBEEF ^ 32'(at + 3);
        checks++;
        if ({dn0[0], er0[0], dn1[0]} !== 3'b100 || rd0[0] !== exp_rd0) begin
            errors++;
            $display("FAIL read_done: got done/err/d1=%b%b%b rdata=%h, need 100 %h",
                     dn0[0], er0[0], dn1[0], rd0[0], exp_rd0);
        end
        tick();
        checks++;
        if ({dn0[0], bsy[0]} !== 2'b00 || rd0[0] !== exp_rd0) begin
            errors++;
            $display("FAIL read_after: got done=%b busy=%b rdata=%h", dn0[0], bsy[0], rd0[0]);
        end
    endtask

    task automatic test_protection();
        int who, at;
        logic [7:0] pa[3] = '{8'hC0, 8'hBF, 8'hFF};
        int         po[3] = '{1, 1, 0};
        logic       pr[3] = '{1'b1, 1'b0, 1'b0};
        for (int t = 0; t < 3; t++) begin
            if (po[t] == 1) begin
                r1v = 1'b1; r1w = 1'b1; r1a = pa[t]; r1d = 32'hC0DE_0000 + 32'(t);
            end else begin
                r0v = 1'b1; r0w = 1'b1; r0a = pa[t]; r0d = 32'hC0DE_0000 + 32'(t);
            end
            wait_grant(who, at);
            checks++;
            if (who != po[t]) begin
                errors++;
                $display("FAIL prot_grant%0d: got %0d, need %0d", t, who, po[t]);
            end
            tick();
            r0v = 1'b0; r1v = 1'b0;
            checks++;
            if ({cwr[0], crd[0]} !== {!pr[t], 1'b0}) begin
                errors++;
                $display("FAIL prot_strobe%0d: got wr=%b rd=%b, need wr=%b", t, cwr[0], crd[0], !pr[t]);
            end
            tick();
            checks++;
            if ((po[t] == 1 && {dn1[0], er1[0], dn0[0]} !== {1'b1, pr[t], 1'b0}) ||
                (po[t] == 0 && {dn0[0], er0[0], dn1[0]} !== 3'b100)) begin
                errors++;
                $display("FAIL prot_done%0d: got d0=%b e0=%b d1=%b e1=%b, need err=%b",
                         t, dn0[0], er0[0], dn1[0], er1[0], pr[t]);
            end
            checks++;
            if (rd0[0] !== exp_rd0) begin
                errors++;
                $display("FAIL prot_rdata_hold%0d: got %h, need %h", t, rd0[0], exp_rd0);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int who, at1, at2;
        r0v = 1'b1; r0w = 1'b0; r0a = 8'h18;
        wait_grant(who, at1);
        tick();
        wait_grant(who, at2);
        checks++;
        if (at2 - at1 != 5) begin
            errors++;
            $display("FAIL b2b_read_spacing: got %0d, need 5", at2 - at1);
        end
        tick();
        r0v = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (dn0[0] !== 1'b1 || rd0[0] !== (32'hDEADBEEF ^ 32'(at2 + 3))) begin
            errors++;
            $display("FAIL b2b_read_done: got done=%b rdata=%h", dn0[0], rd0[0]);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        int who, at, c;
        r0v = 1'b1; r0w = 1'b0; r0a = 8'h30;
        wait_grant(who, c);
        tick();
        r0v = 1'b0;
        tick();
        rst = 1'b0;
        r1v = 1'b1; r1w = 1'b0; r1a = 8'h40;
        tick();
        checks++;
        if ({dn0[0], bsy[0], rd0[0], crd[0], cad[0], rdy1[0]} !== '0) begin
            errors++;
            $display("FAIL midrst_state: got done=%b busy=%b rdata=%h addr=%h rdy1=%b",
                     dn0[0], bsy[0], rd0[0], cad[0], rdy1[0]);
        end
        rst = 1'b1;
        wait_grant(who, at);
        checks++;
        if (who != 1 || at != c + 3) begin
            errors++;
            $display("FAIL midrst_grant: got who=%0d at=+%0d, need 1 at +3", who, at - c);
        end
        tick();
        r1v = 1'b0;
        checks++;
        if (dn0[0] !== 1'b0 || crd[0] !== 1'b1) begin
            errors++;
            $display("FAIL midrst_no_done: got done0=%b rd=%b, need 0 1", dn0[0], crd[0]);
        end
        tick(); tick(); tick();
        checks++;
        if ({dn1[0], er1[0], dn0[0]} !== 3'b100 || rd1[0] !== (32'hDEADBEEF ^ 32'(at + 3))) begin
            errors++;
            $display("FAIL midrst_r1_done: got d1=%b e1=%b d0=%b rdata=%h",
                     dn1[0], er1[0], dn0[0], rd1[0]);
        end
        tick();
    endtask

    task automatic test_sweep();
        int who, at;
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        r0v = 1'b1; r0w = 1'b0; r0a = 8'h50;
        wait_grant(who, at);
        checks++;
        if (rdy0[1] !== 1'b1 || rdy0[2] !== 1'b1) begin
            errors++;
            $display("FAIL sweep_ready: got %b%b, need 11", rdy0[1], rdy0[2]);
        end
        tick();
        r0v = 1'b0;
        for (int d = 1; d <= 8; d++) begin
            checks++;
            if (dn0[1] !== (d == 3) || dn0[2] !== (d == 7)) begin
                errors++;
                $display("FAIL sweep_done_d%0d: got lat1=%b lat5=%b", d, dn0[1], dn0[2]);
            end
            if (d == 3) begin
                checks++;
                if (rd0[1] !== (32'hDEADBEEF ^ 32'(at + 2))) begin
                    errors++;
                    $display("FAIL sweep_rdata_lat1: got %h, need %h", rd0[1], 32'hDEADBEEF ^ 32'(at + 2));
                end
            end
            if (d == 7) begin
                checks++;
                if (rd0[2] !== (32'hDEADBEEF ^ 32'(at + 6))) begin
                    errors++;
                    $display("FAIL sweep_rdata_lat5: got %h, need %h", rd0[2], 32'hDEADBEEF ^ 32'(at + 6));
                end
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b0;
        r0v = 1'b0; r0w = 1'b0; r0a = '0; r0d = '0;
        r1v = 1'b0; r1w = 1'b0; r1a = '0; r1d = '0;
        exp_rd0 = '0;
        test_reset();
        test_round_robin();
        test_read();
        test_protection();
        test_back_to_back();
        test_reset_mid_read();
        test_sweep();
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL strobe_rules: got %0d violations, need 0", viol);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfg_space_arbiter.md
# cfg_space_arbiter

Shares the logical layer's single configuration-space access port (`c_read`/`c_write`/`c_address`/`c_data_in`/`c_data_out`) between two requesters. Requester 0 is the local link-training/control FSM; requester 1 is the sideband register-access handler.

- Arbitration is round-robin.
- Each access is a single beat with fixed read latency.
- Requester 1 is barred from writing the protected register range.
- The block sits between those two agents and the config space, in the `local_clk` domain.

## Interface

Parameters:
- `ADDR_W`, 8: config-space address width.
- `DATA_W`, 32: config-space data width.
- `RD_LAT`, 2: cycles from the `c_read` cycle to valid `c_data_out`. Legal range is 1..15.
- `PROT_BASE`, 8'hC0: requester-1 writes with `addr >= PROT_BASE` are rejected.

Ports (one clock; reset is synchronous and active-low):
- `local_clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `reqN_valid`  in  1  request pending, N ∈ {0,1}.
- `reqN_write`  in  1  1 = write, 0 = read.
- `reqN_addr`  in  ADDR_W  access address.
- `reqN_wdata`  in  DATA_W  write data.
- `reqN_ready`  out  1  accept strobe. The request is taken at the edge where `valid && ready`.
- `reqN_done`  out  1  one-cycle completion pulse.
- `reqN_err`  out  1  valid with `done`; 1 = write rejected.
- `reqN_rdata`  out  DATA_W  read data, valid with `done` for reads.
- `c_read`, `c_write`  out  1  one-cycle access strobes.
- `c_address`  out  ADDR_W  access address.
- `c_data_in`  out  DATA_W  write data to config space.
- `c_data_out`  in  DATA_W  read data from config space.
- `busy`  out  1  high in every state except IDLE.

## Operation

- FSM states are IDLE, ISSUE, WAIT, DONE. Exactly one access is in flight at a time.
- **IDLE**
  - If any `valid` is high, grant one requester and drive its `ready` high combinationally in that cycle.
  - At the edge: latch owner, write flag, address and write data, then go to ISSUE.
  - At most one `ready` is high in any cycle.
- **Arbitration**
  - `last_grant` resets to 1, so requester 0 wins the first contention.
  - When both requesters are valid, the one ≠ `last_grant` wins.
  - When one is valid, it wins.
  - `last_grant` updates on every accept.
- **ISSUE** (exactly 1 cycle)
  - `c_address` and `c_data_in` carry the latched values. These outputs are registered and hold their last value afterwards.
  - Read: `c_read`=1, then go to WAIT with counter = RD_LAT-1.
  - Allowed write: `c_write`=1, then go to DONE.
  - Rejected write (owner 1, write, `addr >= PROT_BASE`): no strobe, set the error flag, then go to DONE.
- **WAIT** (RD_LAT cycles)
  - The counter decrements each cycle.
  - In the cycle the counter = 0, capture `c_data_out` into the owner's `rdata`, then go to DONE.
- **DONE** (1 cycle)
  - The owner's `done`=1. `err` is set as decided in ISSUE (0 for reads and allowed writes).
  - The non-owner's `done`/`err` stay 0.
  - Next state is IDLE. No grant happens in DONE.
- `reqN_rdata` holds its last captured value until the next read completes for that requester.
- Requester inputs are ignored outside IDLE. A requester may drop `valid` after its accept without effect.
- Reset (`rst`=0 at an edge, from any state):
  - Next state is IDLE.
  - All outputs go to 0, including `c_address`, `c_data_in`, `rdata`, `err`, `busy`.
  - `last_grant` goes to 1.
  - An in-flight access is discarded with no `done`.

## Timing

- Accept at edge k.
  - Strobe cycle is k+1.
  - Read: data is sampled in cycle k+1+RD_LAT; `done` is in cycle k+2+RD_LAT.
  - Write (allowed or rejected): `done` is in cycle k+2.
- Back-to-back: the next accept is at the earliest in the IDLE cycle following DONE.
  - Write throughput is 1 access per 3 cycles.
  - Read throughput is 1 access per RD_LAT+3 cycles.
- `c_read` and `c_write` are never high together, and each is never high for more than 1 consecutive cycle.
- `busy` rises in the cycle after accept and falls in the cycle after DONE.

## Test plan

- **Reset:** hold `rst`=0 for 3 cycles with both `valid`=1 → all outputs 0 and no `ready`. Release reset → requester 0 is granted first.
- **Read, RD_LAT=2:** req0 reads 8'h10 and the model returns 32'hDEADBEEF → `c_read` 1 cycle after accept, `req0_done` 4 cycles after accept, `req0_rdata`=32'hDEADBEEF, `err`=0.
- **Round-robin:** both requesters hold `valid` continuously, writing 8'h20 and 8'h21 → grants alternate 0,1,0,1; the accept edges of successive grants are exactly 3 cycles apart.
- **Protection:** req1 writes 8'hC0 → no `c_write`, `req1_done`=1 with `err`=1. req1 writes 8'hBF → `c_write`=1, `err`=0. req0 writes 8'hFF → allowed.
- **Reset mid-read:** assert `rst`=0 in the WAIT cycle → no `done` pulse, next state IDLE. After release, a pending req1 read completes normally.
- **Sweep RD_LAT ∈ {1, 5}:** `done` lands exactly RD_LAT+2 cycles after accept, and `rdata` matches the value presented in cycle k+1+RD_LAT.
